// File: rtl/free_list_if.sv
// Rename-stage free-list port bundle.
//
// Handshake: alloc_req is a request held by the rename stage; alloc_gnt is the
// combinational acknowledge. A tag is transferred (alloc_preg consumed) only at a
// rising clock edge where alloc_req && alloc_gnt. free_en, commit_en and flush are
// single-cycle strobes with no back-pressure; each is sampled at the rising edge.
//
// master : rename/commit logic (drives requests, sees grant, tag, status)
// slave  : free_list (drives grant, tag, status)
interface free_list_if #(
    parameter int PTAG_W = 6,
    parameter int CNT_W  = 5
);
    logic              alloc_req;
    logic              alloc_gnt;
    logic [PTAG_W-1:0] alloc_preg;
    logic              free_en;
    logic [PTAG_W-1:0] free_preg;
    logic              commit_en;
    logic              flush;
    logic [CNT_W-1:0]  free_count;
    logic              empty;
    logic              err;

    modport master (
        output alloc_req, free_en, free_preg, commit_en, flush,
        input  alloc_gnt, alloc_preg, free_count, empty, err
    );

    modport slave (
        input  alloc_req, free_en, free_preg, commit_en, flush,
        output alloc_gnt, alloc_preg, free_count, empty, err
    );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for the rename stage.
//
// Tags ARCH_REGS..PHYS_REGS-1 start in the list; tags below ARCH_REGS hold the
// reset architectural mappings. head is the allocation pointer, tail the return
// pointer, chead the committed-allocation pointer. A flush rewinds head to chead,
// reclaiming every uncommitted allocation in a single cycle.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   fl (slave)  alloc_req/alloc_gnt/alloc_preg, free_en/free_preg, commit_en,
//               flush, free_count, empty, err
//
// Optional build macro FREE_LIST_CHECK_EN: adds an in-list bitmap that detects
// double frees, out-of-range frees, frees while full and commits with nothing in
// flight. err is sticky until reset; an offending free is dropped. Without the
// macro err is tied low (full-drop and commit-ignore still apply).
module free_list #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 48,
    parameter int PTAG_W    = 6,
    parameter int CNT_W     = 5
) (
    input logic        clk,
    input logic        reset,
    free_list_if.slave fl
);
    localparam int DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTAG_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  chead_q, chead_d;
    logic [CNT_W-1:0]  free_count_q, free_count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;

    logic full;
    logic is_empty;
    logic alloc_gnt;
    logic commit_ok;
    logic free_ok;

    assign full      = (free_count_q == CNT_W'(DEPTH));
    assign is_empty  = (free_count_q == '0);
    assign alloc_gnt = fl.alloc_req & ~is_empty & ~fl.flush;
    // A commit beyond the number of outstanding allocations is ignored.
    assign commit_ok = fl.commit_en & (inflight_q != '0);

`ifdef FREE_LIST_CHECK_EN
    logic [PHYS_REGS-1:0] in_list_q, in_list_d;
    logic                 err_q, err_d;
    logic                 free_in_range;
    logic                 free_dup;
    logic                 free_bad;

    assign free_in_range = (int'(fl.free_preg) < PHYS_REGS);
    assign free_dup      = free_in_range ? in_list_q[fl.free_preg] : 1'b0;
    assign free_bad      = fl.free_en & (full | ~free_in_range | free_dup);
    assign free_ok       = fl.free_en & ~free_bad;
    assign err_d         = err_q | free_bad | (fl.commit_en & (inflight_q == '0));

    always_comb begin
        in_list_d = in_list_q;
        if (alloc_gnt) in_list_d[fl.alloc_preg] = 1'b0;
        if (free_ok) in_list_d[fl.free_preg] = 1'b1;
        // Tags between the (post-commit) committed pointer and head go back in.
        if (fl.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i < int'(inflight_q) - int'(commit_ok))
                    in_list_d[fifo_q[chead_d + PTR_W'(i)]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++) in_list_q[i] <= (i >= ARCH_REGS);
            err_q <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            err_q     <= err_d;
        end
    end

    assign fl.err = err_q;
`else
    assign free_ok = fl.free_en & ~full;
    assign fl.err  = 1'b0;
`endif

    always_comb begin
        tail_d       = tail_q + PTR_W'(free_ok);
        chead_d      = chead_q + PTR_W'(commit_ok);
        head_d       = head_q;
        free_count_d = free_count_q;
        inflight_d   = inflight_q;
        if (fl.flush) begin
            // Commit in the same cycle is applied before the rewind.
            head_d       = chead_d;
            free_count_d = free_count_q + inflight_q - CNT_W'(commit_ok) + CNT_W'(free_ok);
            inflight_d   = '0;
        end else begin
            head_d       = head_q + PTR_W'(alloc_gnt);
            free_count_d = free_count_q + CNT_W'(free_ok) - CNT_W'(alloc_gnt);
            inflight_d   = inflight_q + CNT_W'(alloc_gnt) - CNT_W'(commit_ok);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= PTAG_W'(ARCH_REGS + i);
            head_q       <= '0;
            tail_q       <= '0;
            chead_q      <= '0;
            free_count_q <= CNT_W'(DEPTH);
            inflight_q   <= '0;
        end else begin
            if (free_ok) fifo_q[tail_q] <= fl.free_preg;
            head_q       <= head_d;
            tail_q       <= tail_d;
            chead_q      <= chead_d;
            free_count_q <= free_count_d;
            inflight_q   <= inflight_d;
        end
    end

    assign fl.alloc_gnt  = alloc_gnt;
    assign fl.alloc_preg = fifo_q[head_q];
    assign fl.free_count = free_count_q;
    assign fl.empty      = is_empty;
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: a vector table for the per-cycle behaviour, a
// queue-model sequence for pointer wrap and FIFO order, and hand sequences for
// the error flag and asynchronous reset.
module tb_free_list;
    localparam int PTAG_W = 6;
    localparam int CNT_W  = 5;
`ifdef FREE_LIST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    free_list_if #(.PTAG_W(PTAG_W), .CNT_W(CNT_W)) fl_if ();

    free_list #(
        .ARCH_REGS(32), .PHYS_REGS(48), .PTAG_W(PTAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input bit areq, input bit fen, input logic [PTAG_W-1:0] fpreg,
                         input bit cen, input bit flsh);
        fl_if.alloc_req = areq;
        fl_if.free_en   = fen;
        fl_if.free_preg = fpreg;
        fl_if.commit_en = cen;
        fl_if.flush     = flsh;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit              rst;
        bit              areq;
        bit              fen;
        logic [PTAG_W-1:0] fpreg;
        bit              cen;
        bit              flsh;
        bit              egnt;
        int              epreg;
        bit              chkp;
        int              ecnt;
        bit              eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit areq, input bit fen, input int fpreg,
                       input bit cen, input bit flsh, input bit egnt, input int epreg,
                       input bit chkp, input int ecnt, input bit eerr);
        vec_t v;
        v.rst = rst; v.areq = areq; v.fen = fen; v.fpreg = PTAG_W'(fpreg);
        v.cen = cen; v.flsh = flsh; v.egnt = egnt; v.epreg = epreg;
        v.chkp = chkp; v.ecnt = ecnt; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard for wrap sequence ----------------
    logic [PTAG_W-1:0] exp_q[$];
    logic [PTAG_W-1:0] held_q[$];

    initial begin
        reset = 1'b1;
        drive(0, 0, '0, 0, 0);

        // Drain from reset: 32..47, then empty; a free at empty appears next cycle.
        add(1, 0,0,0,0,0, 0,32,1,16,0);
        for (int i = 0; i < 16; i++) add(0, 1,0,0,0,0, 1,32+i,1,16-i,0);
        add(0, 1,0,0,0,0, 0,0,0,0,0);
        add(0, 0,1,5,0,0, 0,0,0,0,0);
        add(0, 0,0,0,0,0, 0,5,1,1,0);
        // Allocate 32,33,34; commit one; flush reclaims 33,34.
        add(1, 1,0,0,0,0, 1,32,1,16,0);
        add(0, 1,0,0,0,0, 1,33,1,15,0);
        add(0, 1,0,0,0,0, 1,34,1,14,0);
        add(0, 0,0,0,1,0, 0,35,1,13,0);
        add(0, 1,0,0,0,1, 0,35,1,13,0);   // flush blocks the grant
        add(0, 1,0,0,0,0, 1,33,1,15,0);
        add(0, 0,0,0,1,1, 0,34,1,14,0);   // commit + flush same cycle
        add(0, 0,0,0,0,0, 0,34,1,14,0);
        add(0, 0,0,0,1,0, 0,34,1,14,0);   // commit with nothing in flight
        add(0, 0,0,0,0,1, 0,34,1,14,1);   // flush must reclaim nothing
        add(0, 0,0,0,0,0, 0,34,1,14,1);
        // Down to 4 free, then alloc+free of tag 7 together; 7 follows 45..47.
        for (int i = 0; i < 12; i++) add(i == 0, 1,0,0,0,0, 1,32+i,1,16-i,0);
        add(0, 1,1,7,0,0, 1,44,1,4,0);
        add(0, 0,0,0,0,0, 0,45,1,4,0);
        add(0, 1,0,0,0,0, 1,45,1,4,0);
        add(0, 1,0,0,0,0, 1,46,1,3,0);
        add(0, 1,0,0,0,0, 1,47,1,2,0);
        add(0, 1,0,0,0,0, 1,7,1,1,0);
        add(0, 1,0,0,0,0, 0,0,0,0,0);
        add(0, 1,1,9,0,0, 0,0,0,0,0);     // freed tag not grantable same cycle
        add(0, 1,0,0,0,0, 1,9,1,1,0);
        // Free while full is dropped; head entry must not be overwritten.
        add(1, 0,1,20,0,0, 0,32,1,16,0);
        add(0, 0,0,0,0,0, 0,32,1,16,1);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            @(negedge clk);
            drive(vecs[k].areq, vecs[k].fen, vecs[k].fpreg, vecs[k].cen, vecs[k].flsh);
            #1;
            check($sformatf("v%0d gnt", k), int'(fl_if.alloc_gnt), int'(vecs[k].egnt));
            check($sformatf("v%0d count", k), int'(fl_if.free_count), vecs[k].ecnt);
            check($sformatf("v%0d empty", k), int'(fl_if.empty), int'(vecs[k].ecnt == 0));
            check($sformatf("v%0d err", k), int'(fl_if.err), int'(CHK & vecs[k].eerr));
            if (vecs[k].chkp)
                check($sformatf("v%0d preg", k), int'(fl_if.alloc_preg), vecs[k].epreg);
        end

        // Wrap: alloc / alloc+free / free pattern, frees return oldest held tag.
        do_reset();
        exp_q.delete();
        held_q.delete();
        for (int t = 0; t < 16; t++) exp_q.push_back(PTAG_W'(32 + t));
        for (int c = 0; c < 40; c++) begin
            bit do_alloc;
            bit do_free;
            bit exp_gnt;
            logic [PTAG_W-1:0] ftag;
            do_alloc = (c % 3) != 2;
            do_free  = ((c % 3) != 0) && (held_q.size() > 0);
            ftag     = do_free ? held_q[0] : '0;
            @(negedge clk);
            drive(do_alloc, do_free, ftag, do_free, 0);
            #1;
            exp_gnt = do_alloc && (exp_q.size() > 0);
            check($sformatf("wrap%0d gnt", c), int'(fl_if.alloc_gnt), int'(exp_gnt));
            check($sformatf("wrap%0d count", c), int'(fl_if.free_count), exp_q.size());
            checks++;
            if (int'(fl_if.free_count) > 16) begin
                errors++;
                $display("FAIL wrap%0d bound: got %0d expected <= 16", c, fl_if.free_count);
            end
            if (exp_gnt) begin
                check($sformatf("wrap%0d preg", c), int'(fl_if.alloc_preg), int'(exp_q[0]));
                held_q.push_back(exp_q.pop_front());
            end
            if (do_free) exp_q.push_back(held_q.pop_front());
        end

        // Double free of tag 40 while full; err sticky; async reset clears it.
        do_reset();
        @(negedge clk);
        drive(0, 1, 6'd40, 0, 0);
        #1;
        check("dup40 count0", int'(fl_if.free_count), 16);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(0, 0, '0, 0, 0);
            #1;
            check($sformatf("dup40 err%0d", c), int'(fl_if.err), int'(CHK));
            check($sformatf("dup40 count%0d", c + 1), int'(fl_if.free_count), 16);
            check($sformatf("dup40 preg%0d", c), int'(fl_if.alloc_preg), 32);
        end
        @(negedge clk);
        drive(1, 0, '0, 0, 0);            // allocate 32, state now non-reset
        @(negedge clk);
        drive(0, 0, '0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("areset count", int'(fl_if.free_count), 16);
        check("areset preg", int'(fl_if.alloc_preg), 32);
        check("areset empty", int'(fl_if.empty), 0);
        check("areset err", int'(fl_if.err), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Non-full double free: 33 is still in the list after allocating 32.
        @(negedge clk);
        drive(1, 0, '0, 0, 0);
        #1;
        check("dup33 gnt", int'(fl_if.alloc_gnt), 1);
        @(negedge clk);
        drive(0, 1, 6'd33, 0, 0);
        #1;
        check("dup33 count0", int'(fl_if.free_count), 15);
        @(negedge clk);
        drive(0, 0, '0, 0, 0);
        #1;
        check("dup33 count1", int'(fl_if.free_count), CHK ? 15 : 16);
        check("dup33 err", int'(fl_if.err), int'(CHK));

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
